// File: rtl/led_status_sequencer.sv
// led_status_sequencer
// Turns a status code (0..3) into 1..4 timed flashes on led_en, followed by a
// dark gap and a one-cycle done_pulse. All timing is in prescaler ticks.
// Optional build macro: LED_STATUS_QUEUE_EN adds a one-entry pending register
// so an event arriving mid-pattern is captured and replayed after the gap.
module led_status_sequencer #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 2,
    parameter int GAP_TICKS = 6,
    parameter int CNT_W     = 24
) (
    input  logic       led_clk,
    input  logic       led_rst,
    input  logic       evt_valid,
    input  logic [1:0] evt_code,
    output logic       evt_ready,
    output logic       led_en,
    output logic       busy,
    output logic       done_pulse
);

    // A parameter of 0 is treated as 1 so every phase lasts at least one tick.
    localparam int DIV_EFF = (TICK_DIV  < 1) ? 1 : TICK_DIV;
    localparam int ON_EFF  = (ON_TICKS  < 1) ? 1 : ON_TICKS;
    localparam int OFF_EFF = (OFF_TICKS < 1) ? 1 : OFF_TICKS;
    localparam int GAP_EFF = (GAP_TICKS < 1) ? 1 : GAP_TICKS;

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(DIV_EFF - 1);
    localparam logic [15:0]      ON_LAST   = 16'(ON_EFF - 1);
    localparam logic [15:0]      OFF_LAST  = 16'(OFF_EFF - 1);
    localparam logic [15:0]      GAP_LAST  = 16'(GAP_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [15:0]      tcnt_q, tcnt_d;
    logic [2:0]       flashes_q, flashes_d;
    logic             led_en_q, led_en_d;
    logic             done_q, done_d;

    logic             tick;
    logic             accept;
    logic             phase_end;
    logic [15:0]      phase_last;

`ifdef LED_STATUS_QUEUE_EN
    logic             pend_valid_q, pend_valid_d;
    logic [1:0]       pend_code_q, pend_code_d;
    // Set on the done cycle when a pattern is already loaded for replay.
    logic             relaunch_q, relaunch_d;

    assign evt_ready = !pend_valid_q;
`else
    assign evt_ready = (state_q == S_IDLE);
`endif

    assign accept     = evt_valid && evt_ready;
    assign busy       = (state_q != S_IDLE);
    assign led_en     = led_en_q;
    assign done_pulse = done_q;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        tcnt_d     = tcnt_q;
        flashes_d  = flashes_q;
        done_d     = 1'b0;
`ifdef LED_STATUS_QUEUE_EN
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        relaunch_d   = relaunch_q;
`endif

        tick = (state_q != S_IDLE) && (presc_q == PRESC_MAX);

        case (state_q)
            S_ON:    phase_last = ON_LAST;
            S_OFF:   phase_last = OFF_LAST;
            S_GAP:   phase_last = GAP_LAST;
            default: phase_last = 16'd0;
        endcase
        phase_end = tick && (tcnt_q == phase_last);

        // Prescaler free-runs while a pattern is active and idles at 0.
        if (state_q == S_IDLE) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (tick) begin
            tcnt_d = tcnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
`ifdef LED_STATUS_QUEUE_EN
                if (relaunch_q) begin
                    relaunch_d = 1'b0;
                    state_d    = S_ON;
                    if (accept) begin
                        pend_valid_d = 1'b1;
                        pend_code_d  = evt_code;
                    end
                end else if (accept) begin
                    flashes_d = {1'b0, evt_code} + 3'd1;
                    state_d   = S_ON;
                end
`else
                if (accept) begin
                    flashes_d = {1'b0, evt_code} + 3'd1;
                    state_d   = S_ON;
                end
`endif
            end
            S_ON: begin
                if (phase_end) begin
                    state_d = S_OFF;
                end
            end
            S_OFF: begin
                if (phase_end) begin
                    if (flashes_q > 3'd1) begin
                        flashes_d = flashes_q - 3'd1;
                        state_d   = S_ON;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
`ifdef LED_STATUS_QUEUE_EN
                    if (pend_valid_q) begin
                        flashes_d    = {1'b0, pend_code_q} + 3'd1;
                        pend_valid_d = 1'b0;
                        relaunch_d   = 1'b1;
                    end else if (accept) begin
                        flashes_d  = {1'b0, evt_code} + 3'd1;
                        relaunch_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef LED_STATUS_QUEUE_EN
        // Any event taken mid-pattern (other than the gap-completion bypass)
        // is parked in the pending register.
        if (accept && (state_q != S_IDLE) && !(state_q == S_GAP && phase_end)) begin
            pend_valid_d = 1'b1;
            pend_code_d  = evt_code;
        end
`endif

        if (state_d != state_q) begin
            tcnt_d = '0;
        end

        led_en_d = (state_d == S_ON);
    end

    // FSM and counter registers with synchronous active-high reset.
    always_ff @(posedge led_clk) begin
        if (led_rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            tcnt_q    <= '0;
            flashes_q <= '0;
            led_en_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef LED_STATUS_QUEUE_EN
            pend_valid_q <= 1'b0;
            pend_code_q  <= '0;
            relaunch_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tcnt_q    <= tcnt_d;
            flashes_q <= flashes_d;
            led_en_q  <= led_en_d;
            done_q    <= done_d;
`ifdef LED_STATUS_QUEUE_EN
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            relaunch_q   <= relaunch_d;
`endif
        end
    end

endmodule
